// File: rtl/bus_upsizer_pkt.sv
// Narrow-to-wide stream upsizer: packs RATIO slave beats into one master word,
// flushing partial words on s_last with per-lane keep and a decoupled output register.
module bus_upsizer_pkt #(
  parameter int unsigned S_DATA_WIDTH = 8,
  parameter int unsigned M_DATA_WIDTH = 32,
  parameter bit          MSB_FIRST    = 1'b0
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   s_val,
  input  logic [S_DATA_WIDTH-1:0]                s_data,
  input  logic                                   s_last,
  output logic                                   s_rdy,
  output logic                                   m_val,
  output logic [M_DATA_WIDTH-1:0]                m_data,
  output logic [M_DATA_WIDTH/S_DATA_WIDTH-1:0]   m_keep,
  output logic                                   m_last,
  input  logic                                   m_rdy
);

  localparam int unsigned RATIO = M_DATA_WIDTH / S_DATA_WIDTH;
  localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] TOP_LANE = CW'(RATIO - 1);

  if ((M_DATA_WIDTH % S_DATA_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
    $error("bus_upsizer_pkt: M_DATA_WIDTH must be an integer multiple (>=2) of S_DATA_WIDTH");
  end

  logic [M_DATA_WIDTH-1:0] gather;
  logic [RATIO-1:0]        gather_keep;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           lane;
  logic [M_DATA_WIDTH-1:0] merged_data;
  logic [RATIO-1:0]        merged_keep;
  logic                    closing;
  logic                    accept;

  assign closing = (cnt == TOP_LANE) || s_last;
  // Only a closing beat needs the output register; others always land in gather.
  assign s_rdy   = !(m_val && !m_rdy && closing);
  assign accept  = s_val && s_rdy;

  always_comb begin
    lane        = MSB_FIRST ? (TOP_LANE - cnt) : cnt;
    merged_data = gather;
    merged_keep = gather_keep;
    merged_data[lane*S_DATA_WIDTH +: S_DATA_WIDTH] = s_data;
    merged_keep[lane] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gather      <= '0;
      gather_keep <= '0;
      cnt         <= '0;
      m_val       <= 1'b0;
      m_data      <= '0;
      m_keep      <= '0;
      m_last      <= 1'b0;
    end else begin
      if (m_val && m_rdy) begin
        m_val <= 1'b0;
      end
      if (accept) begin
        if (closing) begin
          m_data      <= merged_data;
          m_keep      <= merged_keep;
          m_last      <= s_last;
          m_val       <= 1'b1;
          gather      <= '0;
          gather_keep <= '0;
          cnt         <= '0;
        end else begin
          gather      <= merged_data;
          gather_keep <= merged_keep;
          cnt         <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_upsizer_pkt.sv
// Bench for bus_upsizer_pkt: LSB-first and MSB-first instances share stimulus and
// are checked every cycle against a beat-list packet model, plus literal word checks.
module tb_bus_upsizer_pkt;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s_val = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        m_rdy = 1'b1;

  logic        s_rdy0, s_rdy1;
  logic        m_val0, m_val1;
  logic [31:0] m_data0, m_data1;
  logic [3:0]  m_keep0, m_keep1;
  logic        m_last0, m_last1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  bus_upsizer_pkt #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .s_val(s_val), .s_data(s_data), .s_last(s_last),
    .s_rdy(s_rdy0), .m_val(m_val0), .m_data(m_data0), .m_keep(m_keep0),
    .m_last(m_last0), .m_rdy(m_rdy));

  bus_upsizer_pkt #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (
    .clock(clock), .reset(reset), .s_val(s_val), .s_data(s_data), .s_last(s_last),
    .s_rdy(s_rdy1), .m_val(m_val1), .m_data(m_data1), .m_keep(m_keep1),
    .m_last(m_last1), .m_rdy(m_rdy));

  typedef struct {
    logic [31:0] d_lsb;
    logic [31:0] d_msb;
    logic [3:0]  k_lsb;
    logic [3:0]  k_msb;
    logic        last;
  } word_t;

  logic [7:0] cur[$];
  word_t      pend[$];
  word_t      seen[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t make_word(input bit last);
    word_t w;
    w.d_lsb = '0; w.d_msb = '0; w.k_lsb = '0; w.k_msb = '0; w.last = last;
    for (int i = 0; i < cur.size(); i++) begin
      w.d_lsb = w.d_lsb | (32'(cur[i]) << (8 * i));
      w.d_msb = w.d_msb | (32'(cur[i]) << (8 * (3 - i)));
      w.k_lsb[i]     = 1'b1;
      w.k_msb[3 - i] = 1'b1;
    end
    return w;
  endfunction

  function automatic bit model_rdy();
    return !(pend.size() != 0 && !m_rdy && (cur.size() == 3 || s_last));
  endfunction

  // Model: beats collect into a list; a packet end or a fourth beat produces a word.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cur.delete();
      pend.delete();
    end else begin
      bit acc;
      acc = s_val && model_rdy();
      if (pend.size() != 0 && m_rdy) void'(pend.pop_front());
      if (acc) begin
        cur.push_back(s_data);
        if (cur.size() == 4 || s_last) begin
          pend.push_back(make_word(s_last));
          cur.delete();
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("s_rdy_lsb", 32'(s_rdy0), 32'(model_rdy()));
    chk("s_rdy_msb", 32'(s_rdy1), 32'(model_rdy()));
    chk("m_val_lsb", 32'(m_val0), 32'(pend.size() != 0));
    chk("m_val_msb", 32'(m_val1), 32'(pend.size() != 0));
    if (reset) begin
      chk("rst_data", m_data0 | m_data1, 32'h0);
      chk("rst_keep", 32'(m_keep0 | m_keep1), 32'h0);
      chk("rst_last", 32'(m_last0 | m_last1), 32'h0);
    end else if (pend.size() != 0) begin
      chk("m_data_lsb", m_data0, pend[0].d_lsb);
      chk("m_data_msb", m_data1, pend[0].d_msb);
      chk("m_keep_lsb", 32'(m_keep0), 32'(pend[0].k_lsb));
      chk("m_keep_msb", 32'(m_keep1), 32'(pend[0].k_msb));
      chk("m_last", 32'(m_last0), 32'(pend[0].last));
      chk("m_last_msb", 32'(m_last1), 32'(pend[0].last));
    end
    if (!reset && m_val0 && m_rdy)
      seen.push_back('{d_lsb: m_data0, d_msb: m_data1, k_lsb: m_keep0, k_msb: m_keep1, last: m_last0});
  end

  task automatic beat(input logic [7:0] d, input logic l);
    bit ok;
    bit rdy;
    ok = 1'b0;
    s_val = 1'b1; s_data = d; s_last = l;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clock);
      rdy = s_rdy0;
      @(posedge clock);
      #1;
      ok = rdy;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL beat_timeout: beat %h not accepted within 100 cycles", d);
    end
    s_val = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    reset = 1'b0;
    idle(2);

    // Full word, both lane orders.
    beat(8'h10, 0); beat(8'h01, 0); beat(8'h02, 0); beat(8'h04, 0);
    idle(3);

    // Short packet flushed by s_last.
    beat(8'hAA, 0); beat(8'hBB, 1);
    idle(3);

    // Backpressure: word 0 stalls, 0x07 must wait for the drain.
    m_rdy = 1'b0;
    fork
      for (int i = 0; i < 8; i++) beat(8'(i), 0);
      begin idle(10); m_rdy = 1'b1; end
    join
    idle(4);

    // Reset mid-word discards the partial beats.
    beat(8'h55, 0); beat(8'h66, 0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(1);
    beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
    idle(3);

    // Sustained streaming.
    for (int i = 0; i < 32; i++) beat(8'(8'h20 + i), 0);
    idle(4);

    chk("word_count", 32'(seen.size()), 32'd13);
    if (seen.size() == 13) begin
      chk("w0_lsb", seen[0].d_lsb, 32'h04020110);
      chk("w0_msb", seen[0].d_msb, 32'h10010204);
      chk("w0_keep", 32'(seen[0].k_lsb), 32'hF);
      chk("w0_last", 32'(seen[0].last), 32'h0);
      chk("w1_lsb", seen[1].d_lsb, 32'h0000BBAA);
      chk("w1_msb", seen[1].d_msb, 32'hAABB0000);
      chk("w1_keep_lsb", 32'(seen[1].k_lsb), 32'h3);
      chk("w1_keep_msb", 32'(seen[1].k_msb), 32'hC);
      chk("w1_last", 32'(seen[1].last), 32'h1);
      chk("w2_lsb", seen[2].d_lsb, 32'h03020100);
      chk("w3_lsb", seen[3].d_lsb, 32'h07060504);
      chk("w4_lsb", seen[4].d_lsb, 32'h44332211);
      chk("w4_keep", 32'(seen[4].k_lsb), 32'hF);
      chk("w5_lsb", seen[5].d_lsb, 32'h23222120);
      chk("w12_lsb", seen[12].d_lsb, 32'h3F3E3D3C);
      chk("w12_msb", seen[12].d_msb, 32'h3C3D3E3F);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
